// File: rtl/shift_issue_pipe.sv
// Two-stage issue pipe for the RV32I shift unit: S1 decodes and registers the
// barrel shifter controls, S2 captures the shifter result for writeback.
module shift_issue_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         funct3,
    input  logic               funct7_b5,
    input  logic               is_imm,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [SHAMT_W-1:0] imm_shamt,
    input  logic [RD_W-1:0]    rd_addr,
    output logic [XLEN-1:0]    sft_in,
    output logic [SHAMT_W-1:0] sft_amount,
    output logic               sft_right,
    output logic               logic_sft,
    input  logic [XLEN-1:0]    sft_out,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RD_W-1:0]    wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               illegal_op
);

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]    sft_in_q, sft_in_d;
    logic [SHAMT_W-1:0] sft_amount_q, sft_amount_d;
    logic               sft_right_q, sft_right_d;
    logic               logic_sft_q, logic_sft_d;
    logic [RD_W-1:0]    s1_rd_q, s1_rd_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic               illegal_q, illegal_d;

    logic s2_free, s1_adv, accept, legal;
    logic unused_rs2_hi;

    // Only the low SHAMT_W bits of rs2 form the amount (shift is modulo XLEN).
    assign unused_rs2_hi = ^rs2_data[XLEN-1:SHAMT_W];

    assign s2_free  = ~s2_valid_q | wb_ready;
    assign s1_adv   = s1_valid_q & s2_free;
    assign in_ready = ~flush & (~s1_valid_q | s2_free);
    assign accept   = in_valid & in_ready;
    assign legal    = ((funct3 == 3'b001) & ~funct7_b5) | (funct3 == 3'b101);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s2_valid_d   = s2_valid_q;
        sft_in_d     = sft_in_q;
        sft_amount_d = sft_amount_q;
        sft_right_d  = sft_right_q;
        logic_sft_d  = logic_sft_q;
        s1_rd_d      = s1_rd_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        // accept already excludes the flush cycle, so illegal_op is suppressed too
        illegal_d    = accept & ~legal;

        if (accept & legal) begin
            s1_valid_d   = 1'b1;
            sft_in_d     = rs1_data;
            sft_amount_d = is_imm ? imm_shamt : rs2_data[SHAMT_W-1:0];
            sft_right_d  = funct3[2];
            logic_sft_d  = ~(funct3[2] & funct7_b5);
            s1_rd_d      = rd_addr;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            wb_data_d  = sft_out;
            wb_rd_d    = s1_rd_q;
        end else if (wb_ready) begin
            s2_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            sft_in_q     <= '0;
            sft_amount_q <= '0;
            sft_right_q  <= 1'b0;
            logic_sft_q  <= 1'b1;
            s1_rd_q      <= '0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            illegal_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            sft_in_q     <= sft_in_d;
            sft_amount_q <= sft_amount_d;
            sft_right_q  <= sft_right_d;
            logic_sft_q  <= logic_sft_d;
            s1_rd_q      <= s1_rd_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            illegal_q    <= illegal_d;
        end
    end

    assign sft_in     = sft_in_q;
    assign sft_amount = sft_amount_q;
    assign sft_right  = sft_right_q;
    assign logic_sft  = logic_sft_q;
    assign wb_valid   = s2_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign illegal_op = illegal_q;

endmodule
